// File: rtl/reg_bank_top.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_top
// Description : NUM_REGS x DATA_W register bank. It has a synchronous
//               single-port write and a combinational, read_en-gated read.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_top #(
    parameter int NUM_REGS = 14,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_en,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] rd_vec [NUM_REGS];

    // Each register matches its own index on all address bits. Addresses at or
    // above NUM_REGS match no register, so writes to them are dropped.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        localparam logic [ADDR_W-1:0] C_IDX = ADDR_W'(i);

        logic [DATA_W-1:0] reg_d;
        logic [DATA_W-1:0] reg_q;

        always_comb begin
            reg_d = reg_q;
            if (write_en && (addr == C_IDX)) begin
                reg_d = data_in;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                reg_q <= '0;
            end else begin
                reg_q <= reg_d;
            end
        end

        assign rd_vec[i] = reg_q;
    end

    always_comb begin
        data_out = '0;
        if (read_en) begin
            for (int j = 0; j < NUM_REGS; j++) begin
                if (addr == ADDR_W'(j)) begin
                    data_out = rd_vec[j];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bank_top
// Description : Directed and seeded-random self-checking bench for reg_bank_top.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bank_top;

    localparam int C_NUM_REGS = 14;

    logic        clk;
    logic        rst;
    logic        write_en;
    logic        read_en;
    logic [3:0]  addr;
    logic [15:0] data_in;
    logic [15:0] data_out;

    logic [15:0] model [C_NUM_REGS];
    int          n_checks;
    int          n_pass;

    reg_bank_top #(
        .NUM_REGS(14),
        .DATA_W  (16),
        .ADDR_W  (4)
    ) top (
        .clk     (clk),
        .rst     (rst),
        .write_en(write_en),
        .read_en (read_en),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Drive one write at the next negedge. The write commits at the following posedge.
    task automatic do_write(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        write_en = 1'b1;
        read_en  = 1'b0;
        addr     = a;
        data_in  = d;
        @(posedge clk);
        #1;
        write_en = 1'b0;
        if (a < 4'(C_NUM_REGS)) model[a] = d;
    endtask

    task automatic do_read(input string tag, input logic [3:0] a, input logic [15:0] exp);
        @(negedge clk);
        write_en = 1'b0;
        read_en  = 1'b1;
        addr     = a;
        #1;
        check(tag, data_out, exp);
        read_en = 1'b0;
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < C_NUM_REGS; k++) begin
            do_read(tag, 4'(k), model[k]);
        end
    endtask

    initial begin
        logic [15:0] exp_v;
        logic [3:0]  ra;
        logic [15:0] rd;
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        write_en = 1'b0;
        read_en  = 1'b0;
        addr     = '0;
        data_in  = '0;
        for (int k = 0; k < C_NUM_REGS; k++) model[k] = 16'h0000;

        // Hold reset for two edges.
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all("reset_read");

        // Basic write and read of every register.
        for (int i = 0; i < C_NUM_REGS; i++) begin
            do_write(4'(i), 16'h1234 + 16'(i));
            do_read("basic_rw", 4'(i), 16'h1234 + 16'(i));
        end

        // read_en low forces zero even when the register holds data.
        @(negedge clk);
        read_en = 1'b0;
        addr    = 4'd7;
        #1;
        check("read_en_low", data_out, 16'h0000);

        // Extreme values.
        do_write(4'd0, 16'h0000);
        do_write(4'd1, 16'hFFFF);
        do_write(4'd2, 16'hAAAA);
        do_read("extreme_0", 4'd0, 16'h0000);
        do_read("extreme_1", 4'd1, 16'hFFFF);
        do_read("extreme_2", 4'd2, 16'hAAAA);
        check_all("extreme_others");

        // Unmapped addresses ignore writes and read as zero.
        do_write(4'd14, 16'hBEEF);
        do_write(4'd15, 16'hBEEF);
        do_read("unmapped_14", 4'd14, 16'h0000);
        do_read("unmapped_15", 4'd15, 16'h0000);
        check_all("unmapped_others");

        // Same-address read during write: old value before the edge, new value after.
        @(negedge clk);
        write_en = 1'b1;
        read_en  = 1'b1;
        addr     = 4'd3;
        data_in  = 16'hC0DE;
        #1;
        check("rw_same_before", data_out, 16'h1237);
        @(posedge clk);
        #1;
        write_en = 1'b0;
        model[3] = 16'hC0DE;
        check("rw_same_after", data_out, 16'hC0DE);
        read_en = 1'b0;

        // Reset wins over a simultaneous write.
        do_write(4'd5, 16'h5555);
        do_read("pre_reset_5", 4'd5, 16'h5555);
        @(negedge clk);
        rst      = 1'b1;
        write_en = 1'b1;
        addr     = 4'd5;
        data_in  = 16'h1111;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        write_en = 1'b0;
        for (int k = 0; k < C_NUM_REGS; k++) model[k] = 16'h0000;
        do_read("reset_prio_5", 4'd5, 16'h0000);
        check_all("reset_prio_all");

        // Seeded random mix of writes and reads against the model.
        void'($urandom(120));
        for (int n = 0; n < 100; n++) begin
            ra = 4'($urandom_range(0, 15));
            rd = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                do_write(ra, rd);
            end else begin
                exp_v = (ra < 4'(C_NUM_REGS)) ? model[ra] : 16'h0000;
                do_read("random_read", ra, exp_v);
            end
        end
        check_all("random_final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
